// File: rtl/fm_transmitter_pkg.sv
// Shared receiver types: rx state encoding and byte width.
package fm_transmitter_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Fractional-N bit clock: adds uartRate each cycle, ticks when the sum reaches slowRate.
module uart_bit_timer #(
    parameter int slowRate = 76_800_000,
    parameter int uartRate = 12_000_000
) (
    input  logic clkSlow,
    input  logic reset,
    input  logic restart,
    output logic bitTick
);

    localparam int SUM_W = $clog2(slowRate + uartRate + 1);
    localparam int ACC_W = (SUM_W > 32) ? SUM_W : 32;
    localparam logic [ACC_W-1:0] SLOW = ACC_W'(slowRate);
    localparam logic [ACC_W-1:0] STEP = ACC_W'(uartRate);
    localparam logic [ACC_W-1:0] HALF = ACC_W'(slowRate / 2);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // acc stays below slowRate, so sum never exceeds slowRate+uartRate
    assign sum     = acc + STEP;
    assign bitTick = (sum >= SLOW);

    always_ff @(posedge clkSlow) begin
        if (reset) begin
            acc <= '0;
        end else if (restart) begin
            acc <= HALF;
        end else if (bitTick) begin
            acc <= sum - SLOW;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/uart_sample_receiver.sv
// 8N1 UART receiver assembling blockSize bytes into one audio sample word.
// Optional macro UART_GAP_RESYNC_EN: drop a partial block after gapCycles idle cycles.
module uart_sample_receiver
    import fm_transmitter_pkg::*;
#(
    parameter int slowRate  = 76_800_000,
    parameter int uartRate  = 12_000_000,
    parameter int blockSize = 3,
    parameter int gapCycles = 1024
) (
    input  logic                       clkSlow,
    input  logic                       reset,
    input  logic                       uart,
    output logic [8*blockSize-1:0]     sample,
    output logic                       sampleValid,
    output logic                       frameError
);

    localparam int IDX_W = (blockSize > 1) ? $clog2(blockSize) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(blockSize - 1);

    logic                     uart_p0;
    logic                     uart_p1;
    logic                     uart_p2;
    logic                     fall;
    logic                     restart;
    logic                     bitTick;
    rx_state_t                state;
    logic [2:0]               bit_cnt;
    logic [IDX_W-1:0]         idx;
    logic [BYTE_BITS-1:0]     shift;
    logic [8*blockSize-1:0]   blk;
    logic [8*blockSize-1:0]   assembled;

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized level
    always_ff @(posedge clkSlow) begin
        if (reset) begin
            uart_p0 <= 1'b1;
            uart_p1 <= 1'b1;
            uart_p2 <= 1'b1;
        end else begin
            uart_p0 <= uart;
            uart_p1 <= uart_p0;
            uart_p2 <= uart_p1;
        end
    end

    assign fall    = uart_p2 & ~uart_p1;
    assign restart = (state == IDLE) && fall;

    uart_bit_timer #(
        .slowRate (slowRate),
        .uartRate (uartRate)
    ) u_timer (
        .clkSlow (clkSlow),
        .reset   (reset),
        .restart (restart),
        .bitTick (bitTick)
    );

    always_comb begin
        assembled = blk;
        assembled[int'(idx)*BYTE_BITS +: BYTE_BITS] = shift;
    end

`ifdef UART_GAP_RESYNC_EN
    localparam int GAP_W = $clog2(gapCycles + 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    always_ff @(posedge clkSlow) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            idx         <= '0;
            sample      <= '0;
            sampleValid <= 1'b0;
            frameError  <= 1'b0;
`ifdef UART_GAP_RESYNC_EN
            gap_cnt     <= '0;
`endif
        end else begin
            sampleValid <= 1'b0;
            frameError  <= 1'b0;
`ifdef UART_GAP_RESYNC_EN
            gap_cnt     <= '0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
`ifdef UART_GAP_RESYNC_EN
                    end else if (idx != '0) begin
                        if (gap_cnt == GAP_W'(gapCycles - 1)) begin
                            idx <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
`endif
                    end
                end
                START: begin
                    if (bitTick) begin
                        state   <= uart_p1 ? IDLE : DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bitTick) begin
                        state <= IDLE;
                        if (!uart_p1) begin
                            frameError <= 1'b1;
                            idx        <= '0;
                        end else if (idx == LAST_IDX) begin
                            sample      <= assembled;
                            sampleValid <= 1'b1;
                            idx         <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: shift register and partial block carry no reset
    always_ff @(posedge clkSlow) begin
        if (state == DATA && bitTick) begin
            shift <= {uart_p1, shift[BYTE_BITS-1:1]};
        end
        if (state == STOP && bitTick && uart_p1) begin
            blk <= assembled;
        end
    end

endmodule
